// File: rtl/led_seq_pkg.sv
// Shared types and default widths for the LED sequencer slice.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

  localparam int MODE_W       = 2;
  localparam int TICK_DIV_DEF = 50000000;
  localparam int NUM_LEDS_DEF = 2;
  localparam int STEP_W_DEF   = 8;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Config valid/ready port carrying the requested mode and step length.
interface led_seq_ctrl_if
  import led_seq_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [MODE_W-1:0] cfg_mode;
  logic [STEP_W-1:0] cfg_steps;

  modport master (output cfg_valid, output cfg_mode, output cfg_steps, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_mode, input cfg_steps, output cfg_ready);
endinterface

// File: rtl/led_seq_ctrl_tick_gen.sv
// Free-running timebase: tick is high for one clk every TICK_DIV cycles.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: step counter, one-entry config pending register and mode FSM.
// Optional 25% dimming of the LED outputs when LED_SEQ_DIM_EN is defined.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int NUM_LEDS = NUM_LEDS_DEF,
  parameter int STEP_W   = STEP_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  led_seq_ctrl_if.slave       cfg,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_pulse
);

  function automatic logic [NUM_LEDS-1:0] alt_pattern();
    logic [NUM_LEDS-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i += 2) p[i] = 1'b1;
    return p;
  endfunction

  localparam logic [NUM_LEDS-1:0] ALT_INIT   = alt_pattern();
  localparam logic [NUM_LEDS-1:0] CHASE_INIT = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  logic                tick;
  mode_e               mode_q, mode_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic                pend_q, pend_d;
  mode_e               pend_mode_q, pend_mode_d;
  logic [STEP_W-1:0]   pend_steps_q, pend_steps_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d;
  logic                step_pulse_q, step_pulse_d;

  logic [STEP_W-1:0]   steps_eff;
  logic                running, step_evt, accept, apply;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign cfg.cfg_ready = !pend_q;

  always_comb begin
    steps_eff = (steps_q == '0) ? STEP_W'(1) : steps_q;
    running   = enable && (mode_q != MODE_OFF);
    step_evt  = tick && running && (step_cnt_q == steps_eff - STEP_W'(1));
    accept    = cfg.cfg_valid && !pend_q;
    apply     = pend_q && ((mode_q == MODE_OFF) || step_evt);
  end

  always_comb begin
    mode_d       = mode_q;
    steps_d      = steps_q;
    step_cnt_d   = step_cnt_q;
    pend_d       = pend_q;
    pend_mode_d  = pend_mode_q;
    pend_steps_d = pend_steps_q;
    pat_d        = pat_q;
    step_pulse_d = 1'b0;

    if (tick && running) step_cnt_d = step_evt ? '0 : step_cnt_q + 1'b1;

    if (accept) begin
      pend_d       = 1'b1;
      pend_mode_d  = mode_e'(cfg.cfg_mode);
      pend_steps_d = cfg.cfg_steps;
    end

    // An apply swallows a coincident step event: new pattern loads, no advance, no strobe.
    if (apply) begin
      pend_d     = 1'b0;
      mode_d     = pend_mode_q;
      steps_d    = pend_steps_q;
      step_cnt_d = '0;
      unique case (pend_mode_q)
        MODE_OFF:   pat_d = '0;
        MODE_BLINK: pat_d = '1;
        MODE_CHASE: pat_d = CHASE_INIT;
        MODE_ALT:   pat_d = ALT_INIT;
        default:    pat_d = '0;
      endcase
    end else if (step_evt) begin
      step_pulse_d = 1'b1;
      unique case (mode_q)
        MODE_CHASE: pat_d = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
        MODE_BLINK,
        MODE_ALT:   pat_d = ~pat_q;
        default:    pat_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_OFF;
      steps_q      <= STEP_W'(1);
      step_cnt_q   <= '0;
      pend_q       <= 1'b0;
      pend_mode_q  <= MODE_OFF;
      pend_steps_q <= '0;
      pat_q        <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      steps_q      <= steps_d;
      step_cnt_q   <= step_cnt_d;
      pend_q       <= pend_d;
      pend_mode_q  <= pend_mode_d;
      pend_steps_q <= pend_steps_d;
      pat_q        <= pat_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign step_pulse = step_pulse_q;

`ifdef LED_SEQ_DIM_EN
  logic [1:0] dim_q, dim_d;

  always_comb dim_d = dim_q + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dim_q <= '0;
    else        dim_q <= dim_d;
  end

  assign led = pat_q & {NUM_LEDS{dim_q == 2'd0}};
`else
  assign led = pat_q;
`endif

endmodule
